// File: rtl/sample_tx_arbiter_pkg.sv
// Shared types and constants for the sample TX arbiter.
// The SAMPLE_TX_ARBITER_CHKSUM_EN build uses ST_TRL.
package sample_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAP,
        ST_HDR,
        ST_LO,
        ST_TRL
    } state_e;

    localparam int CHW = 3;

    localparam logic [CHW-1:0] CH_DIN   = 3'd0;
    localparam logic [CHW-1:0] CH_ADC0  = 3'd1;
    localparam logic [CHW-1:0] CH_ADC1  = 3'd2;
    localparam logic [CHW-1:0] CH_CURR0 = 3'd3;
    localparam logic [CHW-1:0] CH_CURR1 = 3'd4;

    localparam int HDR_ID_LSB  = 5;
    localparam int HDR_RSV_LSB = 2;
    localparam int HDR_MSB_LSB = 0;

    function automatic logic [7:0] mk_hdr(
        input logic [CHW-1:0] id,
        input logic [1:0]     msbs
    );
        logic [7:0] h;
        h = '0;
        h[HDR_ID_LSB +: 3]  = id;
        h[HDR_RSV_LSB +: 3] = 3'b000;
        h[HDR_MSB_LSB +: 2] = msbs;
        return h;
    endfunction

endpackage

// File: rtl/sample_tx_arbiter_rr_picker.sv
// Combinational round-robin first-one finder.
// Searches req from ptr+1 upward, wrapping modulo N.
module rr_picker #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!valid_o && req_i[(int'(ptr_i) + k) % N]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sample_tx_arbiter.sv
// Round-robin sample-to-UART framer: 2-byte frames, BURST per grant.
// Define SAMPLE_TX_ARBITER_CHKSUM_EN for an XOR trailer per burst.
module sample_tx_arbiter
    import sample_tx_arbiter_pkg::*;
#(
    parameter int NCH   = 5,
    parameter int DW    = 10,
    parameter int BURST = 4,
    parameter int CNTW  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      en,
    input  logic [NCH-1:0]      q_em,
    input  logic [NCH*DW-1:0]   q_data,
    output logic [NCH-1:0]      q_pp,
    input  logic                tx_full,
    output logic                tx_ld,
    output logic [7:0]          tx_byte,
    output logic [CHW-1:0]      grant,
    output logic                busy,
    output logic [CNTW-1:0]     frames
);

    state_e          state_q, state_d;
    logic [CHW-1:0]  grant_q, grant_d;
    logic [CHW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]   sample_q, sample_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [NCH-1:0]  q_pp_q, q_pp_d;
    logic            tx_ld_q, tx_ld_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [CNTW-1:0] frames_q, frames_d;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
    logic [7:0]      acc_q, acc_d;
`endif

    logic [NCH-1:0]  req;
    logic            pick_vld;
    logic [CHW-1:0]  pick_idx;
    logic [3:0]      bcnt_nx;
    logic [7:0]      hdr_byte;

    assign req      = en & ~q_em;
    assign bcnt_nx  = bcnt_q + 4'd1;
    assign hdr_byte = mk_hdr(grant_q, sample_q[9:8]);

    rr_picker #(
        .N  (NCH),
        .IW (CHW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        sample_d  = sample_q;
        bcnt_d    = bcnt_q;
        q_pp_d    = '0;
        tx_ld_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        frames_d  = frames_q;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
        acc_d     = acc_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d          = pick_idx;
                    sample_d         = q_data[int'(pick_idx)*DW +: DW];
                    q_pp_d[pick_idx] = 1'b1;
                    bcnt_d           = '0;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
                    acc_d            = '0;
`endif
                    state_d          = ST_HDR;
                end
            end
            ST_CAP: begin
                sample_d        = q_data[int'(grant_q)*DW +: DW];
                q_pp_d[grant_q] = 1'b1;
                state_d         = ST_HDR;
            end
            ST_HDR: begin
                if (!tx_full) begin
                    tx_ld_d   = 1'b1;
                    tx_byte_d = hdr_byte;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
                    acc_d     = acc_q ^ hdr_byte;
`endif
                    state_d   = ST_LO;
                end
            end
            ST_LO: begin
                if (!tx_full) begin
                    tx_ld_d   = 1'b1;
                    tx_byte_d = sample_q[7:0];
                    frames_d  = frames_q + CNTW'(1);
                    bcnt_d    = bcnt_nx;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
                    acc_d     = acc_q ^ sample_q[7:0];
`endif
                    // q_em here already reflects the pop issued for this frame
                    if (bcnt_nx < 4'(BURST) && en[grant_q] && !q_em[grant_q]) begin
                        state_d = ST_CAP;
                    end else begin
                        ptr_d   = grant_q;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
                        state_d = ST_TRL;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
            ST_TRL: begin
                if (!tx_full) begin
                    tx_ld_d   = 1'b1;
                    tx_byte_d = acc_q;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= CH_DIN;
            ptr_q     <= CHW'(NCH - 1);
            sample_q  <= '0;
            bcnt_q    <= '0;
            q_pp_q    <= '0;
            tx_ld_q   <= 1'b0;
            tx_byte_q <= '0;
            frames_q  <= '0;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            sample_q  <= sample_d;
            bcnt_q    <= bcnt_d;
            q_pp_q    <= q_pp_d;
            tx_ld_q   <= tx_ld_d;
            tx_byte_q <= tx_byte_d;
            frames_q  <= frames_d;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign q_pp    = q_pp_q;
    assign tx_ld   = tx_ld_q;
    assign tx_byte = tx_byte_q;
    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign frames  = frames_q;

endmodule

// File: tb/tb_sample_tx_arbiter.sv
// Bench for sample_tx_arbiter: FWFT queue models, transaction-level
// reference scheduler, directed and randomized scenarios.
module tb_sample_tx_arbiter;

    localparam int NCH   = 5;
    localparam int DW    = 10;
    localparam int BURST = 4;
    localparam int CNTW  = 16;
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    q_em = '1;
    logic [NCH*DW-1:0] q_data = '0;
    logic [NCH-1:0]    q_pp;
    logic              tx_full;
    logic              tx_ld;
    logic [7:0]        tx_byte;
    logic [2:0]        grant;
    logic              busy;
    logic [CNTW-1:0]   frames;

    int unsigned chq[NCH][$];
    logic [7:0]  obs[$];
    int          obs_cyc[$];
    logic [7:0]  exp_q[$];
    int          popcnt[NCH];
    int          exp_pops[NCH];
    int          pp_bad = 0;
    int          cyc = 0;
    int          mptr = NCH - 1;
    int          exp_frames = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    sample_tx_arbiter #(
        .NCH(NCH), .DW(DW), .BURST(BURST), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .q_em(q_em),
        .q_data(q_data), .q_pp(q_pp), .tx_full(tx_full),
        .tx_ld(tx_ld), .tx_byte(tx_byte), .grant(grant),
        .busy(busy), .frames(frames)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    // Queue models pop on q_pp and present the new head before the next edge
    always @(negedge clk) begin : mon
        logic [NCH*DW-1:0] nd;
        logic [NCH-1:0]    ne;
        if (tx_ld) begin
            obs.push_back(tx_byte);
            obs_cyc.push_back(cyc);
        end
        if ($countones(q_pp) > 1) pp_bad <= pp_bad + 1;
        for (int i = 0; i < NCH; i++) begin
            if (q_pp[i]) begin
                if (chq[i].size() == 0) pp_bad <= pp_bad + 1;
                else void'(chq[i].pop_front());
                popcnt[i] <= popcnt[i] + 1;
            end
        end
        nd = '0;
        ne = '1;
        for (int i = 0; i < NCH; i++) begin
            if (chq[i].size() != 0) begin
                ne[i] = 1'b0;
                nd[i*DW +: DW] = DW'(chq[i][0]);
            end
        end
        q_em <= ne;
        q_data <= nd;
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs.delete();
        obs_cyc.delete();
        for (int i = 0; i < NCH; i++) popcnt[i] = 0;
    endtask

    // Reference scheduler: whole bursts from a snapshot of the queues
    task automatic model_build(input logic [NCH-1:0] m);
        int rem[NCH];
        int pos[NCH];
        int ch;
        int n;
        int s;
        bit found;
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] acc;
        exp_q.delete();
        for (int i = 0; i < NCH; i++) begin
            rem[i] = chq[i].size();
            pos[i] = 0;
            exp_pops[i] = 0;
        end
        ch = 0;
        while (1) begin
            found = 1'b0;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (mptr + k) % NCH;
                if (!found && m[c] && rem[c] > 0) begin
                    found = 1'b1;
                    ch = c;
                end
            end
            if (!found) break;
            n = (rem[ch] < BURST) ? rem[ch] : BURST;
            acc = 8'h00;
            for (int k = 0; k < n; k++) begin
                s = int'(chq[ch][pos[ch]]);
                h = {3'(ch), 3'b000, 2'(s >> 8)};
                l = 8'(s);
                exp_q.push_back(h);
                exp_q.push_back(l);
                acc = acc ^ h ^ l;
                pos[ch]++;
                rem[ch]--;
                exp_pops[ch]++;
                exp_frames++;
            end
            if (CHK) exp_q.push_back(acc);
            mptr = ch;
        end
    endtask

    task automatic wait_stream(input int budget, input bit rnd,
                               output bit timed_out);
        int t;
        t = 0;
        while (!(obs.size() >= exp_q.size() && !busy) && t < budget) begin
            if (rnd) tx_full = ($urandom_range(0, 2) == 0);
            tick();
            t++;
        end
        tx_full = 1'b0;
        repeat (4) tick();
        timed_out = (t >= budget);
    endtask

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= obs.size()) return i;
            if (obs[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit pops_ok();
        for (int i = 0; i < NCH; i++)
            if (popcnt[i] != exp_pops[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        en = '0;
        tx_full = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        mptr = NCH - 1;
        exp_frames = 0;
        tick();
        clear_obs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = '0;
        tx_full = 1'b0;
        repeat (2) tick();
        n_chk++;
        if ({q_pp, tx_ld, tx_byte, grant, busy} !== '0)
            $display("FAIL reset_outs: got %h want 0",
                     {q_pp, tx_ld, tx_byte, grant, busy});
        else n_pass++;
        n_chk++;
        if (frames !== '0)
            $display("FAIL reset_frames: got %0d want 0", frames);
        else n_pass++;
        rst_n = 1'b1;
        mptr = NCH - 1;
        exp_frames = 0;
        tick();
        clear_obs();
    endtask

    task automatic test_single();
        clear_obs();
        chq[1].push_back(32'h2A5);
        en = 5'b00010;
        tick();
        n_chk++;
        if (q_pp !== 5'b00010 || busy !== 1'b1 || grant !== 3'd1 || tx_ld !== 1'b0)
            $display("FAIL single_grant: q_pp=%b busy=%b grant=%0d ld=%b want 00010 1 1 0",
                     q_pp, busy, grant, tx_ld);
        else n_pass++;
        tick();
        n_chk++;
        if (tx_ld !== 1'b1 || tx_byte !== 8'h22 || q_pp !== '0)
            $display("FAIL single_hdr: ld=%b byte=%h q_pp=%b want 1 22 0",
                     tx_ld, tx_byte, q_pp);
        else n_pass++;
        tick();
        n_chk++;
        if (tx_ld !== 1'b1 || tx_byte !== 8'hA5 || frames !== 16'd1 || busy !== CHK)
            $display("FAIL single_lo: ld=%b byte=%h frames=%0d busy=%b want 1 a5 1 %b",
                     tx_ld, tx_byte, frames, busy, CHK);
        else n_pass++;
        tick();
        n_chk++;
        if (tx_ld !== CHK)
            $display("FAIL single_after: ld=%b want %b", tx_ld, CHK);
        else n_pass++;
        repeat (3) tick();
        n_chk++;
        if (popcnt[1] != 1 || busy !== 1'b0)
            $display("FAIL single_pops: pops=%0d busy=%b want 1 0", popcnt[1], busy);
        else n_pass++;
        en = '0;
        mptr = 1;
        exp_frames = 1;
    endtask

    task automatic test_burst();
        bit to;
        int d;
        int bad;
        clear_obs();
        for (int k = 0; k < 6; k++) chq[2].push_back($urandom_range(0, 1023));
        model_build(5'b00100);
        en = 5'b00100;
        wait_stream(300, 1'b0, to);
        n_chk++;
        if (to) $display("FAIL burst_timeout: got timeout want done");
        else n_pass++;
        n_chk++;
        if (obs.size() != exp_q.size())
            $display("FAIL burst_len: got %0d want %0d", obs.size(), exp_q.size());
        else n_pass++;
        d = first_diff();
        n_chk++;
        if (d >= 0)
            $display("FAIL burst_bytes: idx %0d got %h want %h", d,
                     (d < obs.size()) ? obs[d] : 8'hxx, exp_q[d]);
        else n_pass++;
        bad = 0;
        for (int k = 1; k < 4; k++)
            if (2*k >= obs_cyc.size() || obs_cyc[2*k] - obs_cyc[2*k-2] != 3) bad++;
        n_chk++;
        if (bad != 0) $display("FAIL burst_rate: got %0d bad gaps want 0", bad);
        else n_pass++;
        n_chk++;
        if (!pops_ok() || frames !== 16'(exp_frames))
            $display("FAIL burst_pops: pops=%0d frames=%0d want %0d %0d",
                     popcnt[2], frames, exp_pops[2], exp_frames);
        else n_pass++;
        en = '0;
    endtask

    task automatic test_round_robin();
        bit to;
        int d;
        int bad;
        int stride;
        do_reset();
        for (int i = 0; i < NCH; i++) chq[i].push_back($urandom_range(0, 1023));
        model_build(5'b11111);
        en = 5'b11111;
        wait_stream(300, 1'b0, to);
        n_chk++;
        if (to || obs.size() != exp_q.size())
            $display("FAIL rr_len: got %0d want %0d", obs.size(), exp_q.size());
        else n_pass++;
        d = first_diff();
        n_chk++;
        if (d >= 0)
            $display("FAIL rr_bytes: idx %0d got %h want %h", d,
                     (d < obs.size()) ? obs[d] : 8'hxx, exp_q[d]);
        else n_pass++;
        stride = CHK ? 3 : 2;
        bad = 0;
        for (int k = 0; k < NCH; k++) begin
            if (k*stride >= obs.size()) bad++;
            else if (obs[k*stride][7:5] != 3'(k)) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL rr_order: got %0d out of order want 0", bad);
        else n_pass++;
        en = '0;
    endtask

    task automatic test_backpressure();
        bit to;
        int d;
        int bad;
        logic [7:0] hold;
        clear_obs();
        tx_full = 1'b1;
        chq[4].push_back($urandom_range(0, 1023));
        chq[4].push_back($urandom_range(0, 1023));
        model_build(5'b10000);
        en = 5'b10000;
        tick();
        hold = tx_byte;
        bad = 0;
        for (int k = 0; k < 7; k++) begin
            if (tx_ld !== 1'b0 || tx_byte !== hold) bad++;
            tick();
        end
        n_chk++;
        if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_chk++;
        if (popcnt[4] != 1) $display("FAIL bp_pops: got %0d want 1", popcnt[4]);
        else n_pass++;
        tx_full = 1'b0;
        wait_stream(300, 1'b0, to);
        d = first_diff();
        n_chk++;
        if (to || d >= 0 || obs.size() != exp_q.size())
            $display("FAIL bp_stream: len %0d diff %0d want len %0d diff -1",
                     obs.size(), d, exp_q.size());
        else n_pass++;
        en = '0;
    endtask

    task automatic test_reset_mid();
        bit to;
        int t;
        int d;
        clear_obs();
        for (int k = 0; k < 3; k++) chq[1].push_back($urandom_range(0, 1023));
        en = 5'b00010;
        t = 0;
        while (tx_ld !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (t >= 20 || {q_pp, tx_ld, tx_byte, grant, busy} !== '0 || frames !== '0)
            $display("FAIL rstmid_outs: got %h frames %0d want 0",
                     {q_pp, tx_ld, tx_byte, grant, busy}, frames);
        else n_pass++;
        repeat (2) tick();
        n_chk++;
        if (popcnt[1] != 1) $display("FAIL rstmid_pops: got %0d want 1", popcnt[1]);
        else n_pass++;
        clear_obs();
        mptr = NCH - 1;
        exp_frames = 0;
        model_build(5'b00010);
        rst_n = 1'b1;
        wait_stream(300, 1'b0, to);
        d = first_diff();
        n_chk++;
        if (to || d >= 0 || obs.size() != exp_q.size())
            $display("FAIL rstmid_stream: len %0d diff %0d want len %0d diff -1",
                     obs.size(), d, exp_q.size());
        else n_pass++;
        n_chk++;
        if (!pops_ok() || frames !== 16'(exp_frames))
            $display("FAIL rstmid_frames: got %0d want %0d", frames, exp_frames);
        else n_pass++;
        en = '0;
    endtask

`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
    task automatic test_chksum();
        bit to;
        clear_obs();
        chq[3].push_back(32'h3FF);
        en = 5'b01000;
        exp_q.delete();
        exp_q.push_back(8'h63);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h9C);
        wait_stream(100, 1'b0, to);
        n_chk++;
        if (to || obs.size() != 3 || first_diff() >= 0)
            $display("FAIL chksum: len %0d first %h want 63 ff 9c",
                     obs.size(), (obs.size() > 0) ? obs[0] : 8'hxx);
        else n_pass++;
        exp_frames++;
        mptr = 3;
        en = '0;
    endtask
`endif

    task automatic test_random();
        bit to;
        int d;
        logic [NCH-1:0] m;
        for (int it = 0; it < 6; it++) begin
            clear_obs();
            m = NCH'($urandom_range(1, 31));
            for (int i = 0; i < NCH; i++) begin
                int n;
                n = $urandom_range(0, 5);
                for (int k = 0; k < n; k++) chq[i].push_back($urandom_range(0, 1023));
            end
            model_build(m);
            en = m;
            wait_stream(1500, 1'b1, to);
            d = first_diff();
            n_chk++;
            if (to || d >= 0 || obs.size() != exp_q.size())
                $display("FAIL rand%0d_stream: len %0d diff %0d want len %0d diff -1",
                         it, obs.size(), d, exp_q.size());
            else n_pass++;
            n_chk++;
            if (!pops_ok() || frames !== 16'(exp_frames))
                $display("FAIL rand%0d_frames: got %0d want %0d", it, frames, exp_frames);
            else n_pass++;
            en = '0;
            for (int i = 0; i < NCH; i++) chq[i].delete();
            repeat (2) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = '0;
        tx_full = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef SAMPLE_TX_ARBITER_CHKSUM_EN
        test_chksum();
`endif
        test_random();
        n_chk++;
        if (pp_bad != 0) $display("FAIL pop_rules: got %0d bad pops want 0", pp_bad);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
